// File: rtl/im_loader.sv
// Byte-stream loader for the instruction memory write port.
// Packs big-endian words, writes them from address 0 and holds the CPU meanwhile.
module im_loader #(
  parameter int WL = 32,
  parameter int AW = 6
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [AW:0]   NWORDS,
  input  logic [7:0]    BYTE_IN,
  input  logic          BYTE_VALID,
  output logic          BYTE_READY,
  output logic          IMWE,
  output logic [AW-1:0] IMWA,
  output logic [WL-1:0] IMWD,
  output logic          CPU_HOLD,
  output logic          DONE
);

  localparam int NB = WL / 8;
  localparam int BW = $clog2(NB + 1);
  localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    FIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [WL-1:0] word_q, word_d;
  logic          rdy_q, rdy_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [WL-1:0] wd_q, wd_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;

  logic [WL-1:0] nxt_word;
  logic [AW:0]   wcnt_inc;
  logic [AW:0]   n_sel;
  logic          take_start;

  assign nxt_word   = (word_q << 8) | WL'(BYTE_IN);
  assign wcnt_inc   = wcnt_q + 1'b1;
  assign n_sel      = (NWORDS > MAX_N) ? MAX_N : NWORDS;
  assign take_start = START && (state_q == IDLE || state_q == FIN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    rdy_d   = rdy_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: ;
      RECV: begin
        if (BYTE_VALID && rdy_q) begin
          word_d = nxt_word;
          if (bcnt_q == BW'(NB - 1)) begin
            bcnt_d  = '0;
            state_d = WRITE;
            rdy_d   = 1'b0;
            we_d    = 1'b1;
            wa_d    = addr_q;
            wd_d    = nxt_word;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        wcnt_d = wcnt_inc;
        if (wcnt_inc == n_q) begin
          state_d = FIN;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = RECV;
          rdy_d   = 1'b1;
        end
      end
      FIN: begin
        // an empty load enters FIN still holding; release it here
        done_d = 1'b1;
        hold_d = 1'b0;
      end
    endcase

    if (take_start) begin
      n_d     = n_sel;
      addr_d  = '0;
      bcnt_d  = '0;
      wcnt_d  = '0;
      done_d  = 1'b0;
      hold_d  = 1'b1;
      rdy_d   = (n_sel != '0);
      state_d = (n_sel == '0) ? FIN : RECV;
    end
  end

  assign BYTE_READY = rdy_q;
  assign IMWE       = we_q;
  assign IMWA       = wa_q;
  assign IMWD       = wd_q;
  assign CPU_HOLD   = hold_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: streams byte vectors and
// checks the captured memory writes against hand-built words.
module tb_im_loader;

  localparam int WL = 32;
  localparam int AW = 6;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [AW:0]   NWORDS;
  logic [7:0]    BYTE_IN;
  logic          BYTE_VALID;
  logic          BYTE_READY;
  logic          IMWE;
  logic [AW-1:0] IMWA;
  logic [WL-1:0] IMWD;
  logic          CPU_HOLD;
  logic          DONE;

  int checks;
  int failures;
  int cyc;
  int acc;
  int last4;
  bit prev_we;

  logic [AW-1:0] wa[$];
  logic [WL-1:0] wd[$];
  logic [WL-1:0] tx[$];

  im_loader #(.WL(WL), .AW(AW)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .NWORDS(NWORDS),
    .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY),
    .IMWE(IMWE),
    .IMWA(IMWA),
    .IMWD(IMWD),
    .CPU_HOLD(CPU_HOLD),
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST_N) begin
      acc = 0;
      prev_we = 1'b0;
    end else begin
      if (prev_we) chk("rdy_k2", 64'(BYTE_READY | DONE), 64'd1);
      if (IMWE) begin
        chk("imwe_lat", 64'(cyc - last4), 64'd1);
        chk("hold_wr", 64'(CPU_HOLD), 64'd1);
        chk("rdy_wr", 64'(BYTE_READY), 64'd0);
        wa.push_back(IMWA);
        wd.push_back(IMWD);
      end
      prev_we = IMWE;
      if (BYTE_VALID && BYTE_READY) begin
        acc++;
        if (acc % 4 == 0) last4 = cyc;
      end
    end
  end

  task automatic start_load(input int n);
    START = 1'b1;
    NWORDS = n[AW:0];
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int t;
    for (int g = 0; g < gap; g++) begin
      BYTE_VALID = 1'b0;
      @(posedge CLK); #1;
    end
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 20) begin
      ok = BYTE_READY;
      @(posedge CLK); #1;
      t++;
    end
    if (!ok) chk("byte_to", 64'(ok), 64'd1);
  endtask

  task automatic send_words(input int gap);
    for (int i = 0; i < tx.size(); i++)
      for (int j = 0; j < 4; j++)
        send_byte(tx[i][31-8*j -: 8], (i == 0 && j == 0) ? 0 : gap);
    BYTE_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!DONE && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("done_to", 64'(DONE), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_cnt"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk({tag, "_addr"}, 64'(wa[i]), 64'(i));
      chk({tag, "_data"}, 64'(wd[i]), 64'(tx[i]));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    acc = 0;
    last4 = 0;
    prev_we = 1'b0;
    RST_N = 1'b0;
    START = 1'b0;
    NWORDS = '0;
    BYTE_IN = '0;
    BYTE_VALID = 1'b0;

    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_rdy", 64'(BYTE_READY), 64'd0);
    chk("rst_we", 64'(IMWE), 64'd0);
    chk("rst_wa", 64'(IMWA), 64'd0);
    chk("rst_wd", 64'(IMWD), 64'd0);
    chk("rst_hold", 64'(CPU_HOLD), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);

    BYTE_IN = 8'hAA;
    BYTE_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("idle_rdy", 64'(BYTE_READY), 64'd0);
    end
    BYTE_VALID = 1'b0;
    chk("idle_wr", 64'(wa.size()), 64'd0);

    tx = '{32'h20080005, 32'h8C090004};
    start_load(2);
    chk("two_hold", 64'(CPU_HOLD), 64'd1);
    chk("two_done0", 64'(DONE), 64'd0);
    chk("two_rdy", 64'(BYTE_READY), 64'd1);
    send_words(0);
    wait_done();
    chk("two_hold_off", 64'(CPU_HOLD), 64'd0);
    check_writes("two", 2);

    wa.delete(); wd.delete();
    start_load(2);
    send_words(2);
    wait_done();
    check_writes("gap", 2);

    wa.delete(); wd.delete();
    start_load(0);
    chk("n0_hold", 64'(CPU_HOLD), 64'd1);
    chk("n0_done0", 64'(DONE), 64'd0);
    chk("n0_rdy", 64'(BYTE_READY), 64'd0);
    @(posedge CLK); #1;
    chk("n0_done", 64'(DONE), 64'd1);
    chk("n0_hold_off", 64'(CPU_HOLD), 64'd0);
    repeat (3) @(posedge CLK); #1;
    chk("n0_wr", 64'(wa.size()), 64'd0);

    tx.delete();
    for (int i = 0; i < 64; i++)
      tx.push_back({8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'hC3});
    wa.delete(); wd.delete();
    start_load(100);
    send_words(0);
    wait_done();
    check_writes("n100", 64);
    BYTE_IN = 8'h77;
    BYTE_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("fin_rdy", 64'(BYTE_READY), 64'd0);
    end
    BYTE_VALID = 1'b0;
    chk("fin_wr", 64'(wa.size()), 64'd64);

    wa.delete(); wd.delete();
    start_load(1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    BYTE_VALID = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("mid_hold", 64'(CPU_HOLD), 64'd0);
    chk("mid_rdy", 64'(BYTE_READY), 64'd0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("mid_wr", 64'(wa.size()), 64'd0);
    tx = '{32'hDEADBEEF};
    start_load(1);
    send_words(0);
    wait_done();
    check_writes("dead", 1);

    tx = '{32'hCAFEF00D};
    wa.delete(); wd.delete();
    start_load(1);
    chk("rs_done0", 64'(DONE), 64'd0);
    chk("rs_hold", 64'(CPU_HOLD), 64'd1);
    send_words(0);
    wait_done();
    check_writes("restart", 1);

    tx = '{32'h01020304, 32'h05060708};
    wa.delete(); wd.delete();
    start_load(2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    BYTE_VALID = 1'b0;
    START = 1'b1;
    NWORDS = 7'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("ign_rdy", 64'(BYTE_READY), 64'd1);
    chk("ign_hold", 64'(CPU_HOLD), 64'd1);
    for (int j = 2; j < 8; j++) send_byte(8'(j + 1), 0);
    BYTE_VALID = 1'b0;
    wait_done();
    check_writes("ign", 2);

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and issues one write per word into the instruction memory write port, at consecutive addresses starting from 0.
- Holds the processor (CPU_HOLD) for the whole load, then raises DONE so a program can be swapped in without re-elaborating the memory image.

Parameters:
- WL, 32, instruction word length in bits; must be a multiple of 8.
- AW, 6, instruction memory address width (64 locations).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- NWORDS  input  AW+1  number of words to load; latched on the accepted START.
- BYTE_IN  input  8  stream data byte.
- BYTE_VALID  input  1  BYTE_IN is valid.
- BYTE_READY  output  1  loader can accept a byte this cycle.
- IMWE  output  1  instruction memory write enable; high for exactly one cycle per word.
- IMWA  output  AW  instruction memory write address.
- IMWD  output  WL  instruction memory write data.
- CPU_HOLD  output  1  processor must stall/hold PC while high.
- DONE  output  1  last load completed; sticky until the next START or reset.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, BYTE_READY=0, IMWE=0, IMWA=0, IMWD=0, CPU_HOLD=0, DONE=0, byte count=0, word count=0.
- All outputs are registered. Memory contents are not owned by this block and are unaffected by reset.
- States: IDLE, RECV, WRITE, FIN.
- IDLE, or FIN, with START=1:
  - Latch N = min(NWORDS, 2**AW); clear address, byte and word counters; clear DONE; set CPU_HOLD=1.
  - If N=0, go to FIN directly: DONE=1 next cycle, CPU_HOLD=0, no writes.
  - Otherwise go to RECV.
- RECV: BYTE_READY=1.
  - A byte is accepted only in a cycle where BYTE_VALID=1 and BYTE_READY=1.
  - Accepted bytes shift into the word register MSB-first: byte 0 goes to bits WL-1..WL-8, and the last byte goes to bits 7..0.
  - BYTE_VALID with BYTE_READY=0 does not transfer.
  - The source must hold BYTE_IN stable until the transfer occurs.
  - Once WL/8 bytes are accepted, go to WRITE. BYTE_READY is low in the cycle after the final byte.
- WRITE (exactly 1 cycle): IMWE=1, IMWA=current address, IMWD=assembled word, BYTE_READY=0.
  - Next cycle: address+1, word count+1.
  - If word count+1 = N, go to FIN; otherwise go to RECV.
- Latency: final byte accepted in cycle k → IMWE high in cycle k+1 → BYTE_READY high again in cycle k+2.
- Peak throughput: WL/8 bytes per (WL/8 + 1) cycles.
- FIN: DONE=1, CPU_HOLD=0, BYTE_READY=0, IMWE=0; IMWA/IMWD hold their last values.
  - START in FIN begins a new load from address 0.
- START in RECV or WRITE is ignored, with no effect on counters or N.
- Address wrap: with N=2**AW, the last write goes to address 2**AW-1. The loader never writes past N words, so no wrap occurs.
- Bytes presented while in IDLE or FIN are not accepted (BYTE_READY=0) and do not alter the word register.
- Reset mid-load: immediate return to reset values. The partial word is discarded and is never written. Words already written remain in memory. CPU_HOLD drops asynchronously with reset.
- Simultaneous START and BYTE_VALID in IDLE: START is taken; the byte is not accepted (BYTE_READY was 0).

Test Plan:
- Reset then idle: hold RST_N=0 for 3 cycles, release → all outputs 0. BYTE_VALID=1 with BYTE_IN=8'hAA for 5 cycles → BYTE_READY stays 0, no IMWE.
- Two-word load: START with NWORDS=2; stream 20,08,00,05,8C,09,00,04 with BYTE_VALID held high.
  - Required: IMWE pulses at IMWA=0 with IMWD=32'h20080005, then at IMWA=1 with IMWD=32'h8C090004, one cycle after each 4th byte.
  - Then DONE=1 and CPU_HOLD=0; CPU_HOLD=1 throughout the load.
- Backpressure/gaps: same load as the two-word case with BYTE_VALID toggled 1,0,0,1,… → identical writes. No byte is counted in a VALID=0 cycle.
- NWORDS=0 → no IMWE; DONE=1 two cycles after START. NWORDS=100 → exactly 64 writes at addresses 0..63, then DONE.
- Reset mid-word: START NWORDS=1; send 3 bytes; assert RST_N=0 → IMWE never asserts and CPU_HOLD=0 immediately.
  - After release, START NWORDS=1 with bytes DE,AD,BE,EF → write 32'hDEADBEEF at address 0.
- Restart from FIN and ignored START: after DONE, START NWORDS=1 → DONE clears the next cycle and the load restarts at IMWA=0. A START pulse mid-RECV leaves N and the counters unchanged.
